// File: rtl/sprite_draw.sv
// Sprite blitter: walks sprite RAM entries {x,y,colour,stop} and issues plot strobes offset by a base.
// Optional feature macro: SPRITE_TRANSPARENT_EN (colour 3'b000 suppresses plot).
module sprite_draw #(
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned MAX_ENTRIES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  base_x,
  input  logic [6:0]  base_y,
  input  logic [15:0] ram_data,
  output logic [9:0]  addr_read,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = 10;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;
  localparam int unsigned LW = 3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PLOT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   bx_q, bx_d;
  logic [YW-1:0]   by_q, by_d;
  logic            stop_q, stop_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   col_q, col_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      stop_q  <= 1'b0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      stop_q  <= stop_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; plot and done are single-cycle strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    stop_d  = stop_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    plot_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bx_d    = base_x;
          by_d    = base_y;
          addr_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + LW'(1);
        // Address is held steady, so data is valid once the read latency has elapsed
        if (cnt_q == LW'(RD_LAT - 1)) begin
          stop_d  = ram_data[0];
          x_d     = bx_q + {2'b00, ram_data[15:10]};
          y_d     = by_q + {1'b0, ram_data[9:4]};
          col_d   = ram_data[3:1];
`ifdef SPRITE_TRANSPARENT_EN
          plot_d  = (ram_data[3:1] != 3'b000);
`else
          plot_d  = 1'b1;
`endif
          state_d = S_PLOT;
        end
      end
      S_PLOT: begin
        if (!stop_q || addr_q == AW'(MAX_ENTRIES - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + AW'(1);
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign addr_read  = addr_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw (RD_LAT=2): drawing, wrap, transparency, long walk, start-while-busy, reset.
`timescale 1ns/1ps
module tb_sprite_draw;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [7:0]  base_x;
  logic [6:0]  base_y;
  logic [15:0] ram_data;
  logic [9:0]  addr_read;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] mem [0:1023];
  logic [9:0]  addr_p;

  int         n_plots, done_at, n_done, max_addr, busy0, busy_at_done, done_addr;
  int         pcyc [0:1099];
  logic [7:0] px   [0:1099];
  logic [6:0] py   [0:1099];
  logic [2:0] pc   [0:1099];

  sprite_draw #(.RD_LAT(2), .MAX_ENTRIES(1024)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_x(base_x), .base_y(base_y),
    .ram_data(ram_data), .addr_read(addr_read), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM model: one address register stage plus lookup gives data valid RD_LAT-1 cycles after addr change
  always @(posedge clk) addr_p <= addr_read;
  assign ram_data = mem[addr_p];

  function automatic logic [15:0] ent(input int x, input int y, input int c, input int s);
    ent = {6'(x), 6'(y), 3'(c), 1'(s)};
  endfunction

  // Pulse start, then record plot/done activity; index i is the cycle after edge E0+i
  task automatic draw(input logic [7:0] bx, input logic [6:0] by, input int limit,
                      input int p1, input int p2);
    @(negedge clk);
    base_x = bx; base_y = by; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_plots = 0; done_at = -1; n_done = 0; max_addr = 0; busy0 = busy;
    busy_at_done = -1; done_addr = -1;
    for (int i = 0; i < limit; i++) begin
      if (i > 0) @(negedge clk);
      if (plot && n_plots < 1100) begin
        pcyc[n_plots] = i; px[n_plots] = vga_x; py[n_plots] = vga_y; pc[n_plots] = vga_colour;
        n_plots++;
      end
      if (int'(addr_read) > max_addr) max_addr = int'(addr_read);
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = i; busy_at_done = int'(busy); done_addr = int'(addr_read);
        end
      end
      start = (i == p1 || i == p2);
      if (start) begin base_x = 8'd100; base_y = 7'd100; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; base_x = '0; base_y = '0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({addr_read, vga_x, vga_y, vga_colour, plot, busy, done} !== 32'd0)
      $display("FAIL reset_outputs got %h want 0", {addr_read, vga_x, vga_y, vga_colour, plot, busy, done});
    else pass_cnt++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    mem[0] = ent(3, 5, 4, 1); mem[1] = ent(4, 5, 4, 1); mem[2] = ent(0, 6, 2, 0);
    mem[3] = ent(9, 9, 1, 1);
    draw(8'd10, 7'd20, 14, -1, -1);
    total_cnt++;
    if (n_plots !== 3) $display("FAIL basic_nplots got %0d want 3", n_plots); else pass_cnt++;
    total_cnt++;
    if (n_plots >= 3 && {pcyc[0], pcyc[1], pcyc[2]} === {32'd2, 32'd5, 32'd8} &&
        {px[0], py[0], pc[0]} === {8'd13, 7'd25, 3'd4} &&
        {px[1], py[1], pc[1]} === {8'd14, 7'd25, 3'd4} &&
        {px[2], py[2], pc[2]} === {8'd10, 7'd26, 3'd2}) pass_cnt++;
    else $display("FAIL basic_plots got c0=%0d (%0d,%0d,%0d) c2=%0d (%0d,%0d,%0d) want 2 (13,25,4) / 8 (10,26,2)",
                  pcyc[0], px[0], py[0], pc[0], pcyc[2], px[2], py[2], pc[2]);
    total_cnt++;
    if (done_at !== 9 || n_done !== 1) $display("FAIL basic_done got at=%0d n=%0d want at=9 n=1", done_at, n_done);
    else pass_cnt++;
    total_cnt++;
    if (max_addr !== 2) $display("FAIL basic_max_addr got %0d want 2", max_addr); else pass_cnt++;
    total_cnt++;
    if (busy0 !== 1 || busy_at_done !== 0)
      $display("FAIL basic_busy got start=%0d at_done=%0d want 1/0", busy0, busy_at_done);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    mem[0] = ent(10, 10, 7, 0);
    draw(8'd250, 7'd120, 8, -1, -1);
    total_cnt++;
    if (n_plots !== 1 || pcyc[0] !== 2 || px[0] !== 8'd4 || py[0] !== 7'd2 || pc[0] !== 3'd7)
      $display("FAIL wrap_plot got n=%0d c=%0d (%0d,%0d,%0d) want n=1 c=2 (4,2,7)",
               n_plots, pcyc[0], px[0], py[0], pc[0]);
    else pass_cnt++;
    total_cnt++;
    if (done_at !== 3) $display("FAIL wrap_done got %0d want 3", done_at); else pass_cnt++;
  endtask

  task automatic test_transparent;
    mem[0] = ent(1, 1, 5, 1); mem[1] = ent(2, 1, 0, 1); mem[2] = ent(3, 1, 6, 0);
    draw(8'd0, 7'd0, 14, -1, -1);
`ifdef SPRITE_TRANSPARENT_EN
    total_cnt++;
    if (n_plots !== 2 || pcyc[0] !== 2 || pcyc[1] !== 8 || px[1] !== 8'd3 || pc[1] !== 3'd6)
      $display("FAIL transp_plots got n=%0d c1=%0d x1=%0d col1=%0d want n=2 c1=8 x1=3 col1=6",
               n_plots, pcyc[1], px[1], pc[1]);
    else pass_cnt++;
`else
    total_cnt++;
    if (n_plots !== 3 || pcyc[1] !== 5 || px[1] !== 8'd2 || pc[1] !== 3'd0)
      $display("FAIL transp_plots got n=%0d c1=%0d x1=%0d col1=%0d want n=3 c1=5 x1=2 col1=0",
               n_plots, pcyc[1], px[1], pc[1]);
    else pass_cnt++;
`endif
    total_cnt++;
    if (done_at !== 9) $display("FAIL transp_done got %0d want 9", done_at); else pass_cnt++;
  endtask

  task automatic test_no_stop;
    for (int i = 0; i < 1024; i++) mem[i] = ent(i % 64, (i / 64) % 64, (i % 8) | 1, 1);
    draw(8'd0, 7'd0, 3080, -1, -1);
    total_cnt++;
    if (n_plots !== 1024) $display("FAIL nostop_nplots got %0d want 1024", n_plots); else pass_cnt++;
    total_cnt++;
    if (done_at !== 3072 || done_addr !== 1023)
      $display("FAIL nostop_done got at=%0d addr=%0d want at=3072 addr=1023", done_at, done_addr);
    else pass_cnt++;
    total_cnt++;
    if (n_plots < 1024 || pcyc[1023] !== 3071 || px[1023] !== 8'd63 || py[1023] !== 7'd15 || pc[1023] !== 3'd7)
      $display("FAIL nostop_last got c=%0d (%0d,%0d,%0d) want c=3071 (63,15,7)",
               pcyc[1023], px[1023], py[1023], pc[1023]);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy;
    mem[0] = ent(5, 6, 3, 0);
    draw(8'd10, 7'd20, 14, 0, 3);
    total_cnt++;
    if (n_plots !== 1 || px[0] !== 8'd15 || py[0] !== 7'd26 || pc[0] !== 3'd3)
      $display("FAIL busy_start_plot got n=%0d (%0d,%0d,%0d) want n=1 (15,26,3)", n_plots, px[0], py[0], pc[0]);
    else pass_cnt++;
    total_cnt++;
    if (done_at !== 3 || n_done !== 1 || busy !== 1'b0)
      $display("FAIL busy_start_done got at=%0d n=%0d busy=%0d want at=3 n=1 busy=0", done_at, n_done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_draw;
    int seen;
    mem[0] = ent(3, 5, 4, 1); mem[1] = ent(4, 5, 4, 1); mem[2] = ent(0, 6, 2, 0);
    draw(8'd10, 7'd20, 7, -1, -1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    total_cnt++;
    if ({addr_read, vga_x, vga_y, vga_colour, plot, busy, done} !== 32'd0)
      $display("FAIL midreset_outputs got %h want 0", {addr_read, vga_x, vga_y, vga_colour, plot, busy, done});
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || plot || busy) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL midreset_idle got %0d active cycles want 0", seen); else pass_cnt++;
    draw(8'd10, 7'd20, 14, -1, -1);
    total_cnt++;
    if (n_plots !== 3 || pcyc[0] !== 2 || px[0] !== 8'd13 || py[0] !== 7'd25 || done_at !== 9)
      $display("FAIL midreset_redraw got n=%0d c0=%0d (%0d,%0d) done=%0d want n=3 c0=2 (13,25) done=9",
               n_plots, pcyc[0], px[0], py[0], done_at);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    test_reset;
    test_basic;
    test_wrap;
    test_transparent;
    test_no_stop;
    test_start_while_busy;
    test_reset_mid_draw;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
